result_checker: RTL and testbench
=================================

# result_checker

Parametrised, sequential successor to the team's combinational 32-bit result comparator. It accepts a stream of test/gold result pairs over a valid/ready handshake and compares each pair under a bit mask. It counts vectors and mismatches, captures the first failing vector, and reports a registered pass/fail verdict once a programmed number of vectors has been checked. It sits between a DUT output stage and the testbench or self-test scoreboard.

## Interface
Parameters:
- WIDTH, 32, bit width of test_result, gold_result and mask
- CNT_W, 16, width of all vector counters and indices

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a run, clears counters and latches num_vec
- num_vec  input  CNT_W  number of vectors in the run; sampled only when start=1
- in_valid  input  1  test_result/gold_result/mask are valid this cycle
- in_ready  output  1  checker accepts a vector this cycle
- test_result  input  WIDTH  value produced by the DUT
- gold_result  input  WIDTH  expected value
- mask  input  WIDTH  1 = compare this bit, 0 = ignore this bit
- match  output  1  registered compare result of the last accepted vector
- match_valid  output  1  one-cycle strobe qualifying match
- vec_count  output  CNT_W  vectors accepted in the current run
- err_count  output  CNT_W  mismatches in the current run; saturates at all-ones
- first_err_idx  output  CNT_W  vec_count value of the first mismatching vector, 0-based
- first_err_test  output  WIDTH  test_result of the first mismatch
- first_err_gold  output  WIDTH  gold_result of the first mismatch
- busy  output  1  state is RUN
- done  output  1  state is DONE
- pass  output  1  done=1 and err_count=0

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE:
  - start=1 with num_vec≠0 -> RUN.
  - start=1 with num_vec=0 -> DONE.
  - in_valid is ignored.
- RUN:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready.
  - On accept, vec_count increments.
  - The vector is a mismatch when ((test_result ^ gold_result) & mask) ≠ 0. A mismatch increments err_count, saturating.
  - The first mismatch of a run (err_count=0 before the accept) loads first_err_idx with the pre-increment vec_count, and loads first_err_test and first_err_gold.
  - The accept that brings vec_count to the latched num_vec -> DONE.
- DONE:
  - in_ready=0.
  - Counters and capture registers hold.
  - start begins a new run.
- start in RUN restarts the run: counters and capture registers clear, num_vec is re-latched, state stays RUN. A vector presented in the same cycle as start is not accepted.
- mask=0 makes every vector a match.

## Timing
- Reset values:
  - 0: in_ready, match, match_valid, vec_count, err_count, first_err_idx, first_err_test, first_err_gold, busy, done, pass.
  - State: IDLE.
- Compare latency is 1 cycle. match and match_valid assert in the cycle after the accept edge. match_valid is high exactly one cycle per accepted vector. Back-to-back accepts give back-to-back strobes.
- done, pass and the final counts become visible in the same cycle as the final match_valid strobe.
- start with num_vec=0: done=1 and pass=1 in the next cycle.
- start clears counters one cycle after the start edge; busy asserts on that same cycle.
- in_ready is a pure function of state, with no combinational path from in_valid.
- err_count at all-ones stays all-ones. vec_count never exceeds num_vec.
- reset asserted mid-run takes effect immediately and asynchronously. All outputs return to reset values. Inputs are ignored until reset deasserts and a new start pulse arrives.

## Structure
- Package checker_pkg holds the state enum typedef chk_state_t (IDLE, RUN, DONE) and default parameter constants.
- Sub-module masked_compare is combinational: inputs a, b and mask, output eq. It is parametrised by WIDTH and instantiated once.
- The top level contains the FSM, the counters, the capture registers and the output registers.

## Test plan
- Directed vectors with num_vec=5 and mask=32'hFFFFFFFF, pairs 0/0, 1/0, 0/1, FFFFFFFF/FFFFFFFF, A5A5A5A5/A5A5A5A5:
  - Required: match sequence 1,0,0,1,1; err_count=2; first_err_idx=1; first_err_test=1; first_err_gold=0; done=1; pass=0.
- Masking with mask=32'hFFFF0000, test=1234ABCD, gold=1234FFFF:
  - Required: match=1, err_count=0, pass=1.
- Handshake with in_valid toggled every other cycle and num_vec=3:
  - Required: exactly 3 match_valid strobes; in_ready drops the cycle done rises.
  - Extra valid vectors presented in DONE are not counted.
- Boundary start with num_vec=0:
  - Required: done=pass=1 next cycle, vec_count=0.
- Saturation with CNT_W=4 and 20 mismatching vectors (num_vec=15, then restart via start mid-run):
  - Required: err_count holds at 4'hF.
  - After the restart, counters read 0 and busy stays 1.
- Reset mid-run after 2 of 4 vectors:
  - Required: all outputs 0 immediately, without waiting for a clk edge.
  - A new start with num_vec=1 and a matching vector gives pass=1.

Source files
------------

// File: rtl/checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : checker_pkg
// Description : Shared state encoding and default sizes for result_checker.
// Revision    : 1.0 - initial release
// ============================================================================
package checker_pkg;

    localparam int c_default_width = 32;
    localparam int c_default_cnt_w = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/masked_compare.sv
`default_nettype none
// ============================================================================
// Module      : masked_compare
// Description : Combinational equality of a and b over the bits set in mask.
// Revision    : 1.0 - initial release
// ============================================================================
module masked_compare
    import checker_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    output logic             eq
);

    logic [WIDTH-1:0] w_diff;

    assign w_diff = (a ^ b) & mask;
    assign eq     = (w_diff == '0);

endmodule
`default_nettype wire

// File: rtl/result_checker.sv
`default_nettype none
// ============================================================================
// Module      : result_checker
// Description : Streams test/gold pairs over valid/ready, compares them under
//               a mask, counts mismatches and reports a registered verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module result_checker
    import checker_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = c_default_cnt_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] test_result,
    input  logic [WIDTH-1:0] gold_result,
    input  logic [WIDTH-1:0] mask,
    output logic             match,
    output logic             match_valid,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_test,
    output logic [WIDTH-1:0] first_err_gold,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    chk_state_t       r_state;
    chk_state_t       w_state_next;
    logic [CNT_W-1:0] r_num_vec;
    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_first_err_idx;
    logic [WIDTH-1:0] r_first_err_test;
    logic [WIDTH-1:0] r_first_err_gold;
    logic             r_match;
    logic             r_match_valid;

    logic             w_eq;
    logic             w_accept;
    logic [CNT_W-1:0] w_vec_next;

    masked_compare #(
        .WIDTH (WIDTH)
    ) u_masked_compare (
        .a    (test_result),
        .b    (gold_result),
        .mask (mask),
        .eq   (w_eq)
    );

    // start has priority, so a vector presented alongside it is dropped
    assign w_accept   = in_valid && (r_state == RUN) && !start;
    assign w_vec_next = r_vec_count + c_cnt_one;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = (num_vec != '0) ? RUN : DONE;
        end else if (w_accept && (w_vec_next == r_num_vec)) begin
            w_state_next = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_vec        <= '0;
            r_vec_count      <= '0;
            r_err_count      <= '0;
            r_first_err_idx  <= '0;
            r_first_err_test <= '0;
            r_first_err_gold <= '0;
            r_match          <= 1'b0;
            r_match_valid    <= 1'b0;
        end else begin
            r_match_valid <= w_accept;
            if (start) begin
                r_num_vec        <= num_vec;
                r_vec_count      <= '0;
                r_err_count      <= '0;
                r_first_err_idx  <= '0;
                r_first_err_test <= '0;
                r_first_err_gold <= '0;
            end else if (w_accept) begin
                r_match     <= w_eq;
                r_vec_count <= w_vec_next;
                if (!w_eq) begin
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + c_cnt_one;
                    end
                    // err_count of zero marks the first failure of this run
                    if (r_err_count == '0) begin
                        r_first_err_idx  <= r_vec_count;
                        r_first_err_test <= test_result;
                        r_first_err_gold <= gold_result;
                    end
                end
            end
        end
    end

    assign in_ready       = (r_state == RUN);
    assign busy           = (r_state == RUN);
    assign done           = (r_state == DONE);
    assign pass           = (r_state == DONE) && (r_err_count == '0);
    assign match          = r_match;
    assign match_valid    = r_match_valid;
    assign vec_count      = r_vec_count;
    assign err_count      = r_err_count;
    assign first_err_idx  = r_first_err_idx;
    assign first_err_test = r_first_err_test;
    assign first_err_gold = r_first_err_gold;

endmodule
`default_nettype wire

// File: tb/tb_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_checker
// Description : Directed self-checking bench for result_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_checker;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_vec;
    logic        in_valid;
    logic [31:0] test_result;
    logic [31:0] gold_result;
    logic [31:0] mask;

    logic        in_ready, match, match_valid, busy, done, pass;
    logic [15:0] vec_count, err_count, first_err_idx;
    logic [31:0] first_err_test, first_err_gold;

    logic        start4;
    logic [3:0]  num_vec4;
    logic        in_ready4, match4, match_valid4, busy4, done4, pass4;
    logic [3:0]  vec_count4, err_count4, first_err_idx4;
    logic [31:0] first_err_test4, first_err_gold4;

    int n_checks;
    int n_errors;

    result_checker #(.WIDTH(32), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_vec        (num_vec),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .test_result    (test_result),
        .gold_result    (gold_result),
        .mask           (mask),
        .match          (match),
        .match_valid    (match_valid),
        .vec_count      (vec_count),
        .err_count      (err_count),
        .first_err_idx  (first_err_idx),
        .first_err_test (first_err_test),
        .first_err_gold (first_err_gold),
        .busy           (busy),
        .done           (done),
        .pass           (pass)
    );

    result_checker #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .start          (start4),
        .num_vec        (num_vec4),
        .in_valid       (in_valid),
        .in_ready       (in_ready4),
        .test_result    (test_result),
        .gold_result    (gold_result),
        .mask           (mask),
        .match          (match4),
        .match_valid    (match_valid4),
        .vec_count      (vec_count4),
        .err_count      (err_count4),
        .first_err_idx  (first_err_idx4),
        .first_err_test (first_err_test4),
        .first_err_gold (first_err_gold4),
        .busy           (busy4),
        .done           (done4),
        .pass           (pass4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] t1_test [5];
        logic [31:0] t1_gold [5];
        logic        t1_match [5];
        int          strobes;

        n_checks = 0;
        n_errors = 0;
        t1_test  = '{32'h0, 32'h1, 32'h0, 32'hFFFFFFFF, 32'hA5A5A5A5};
        t1_gold  = '{32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hA5A5A5A5};
        t1_match = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; start = 1'b0; num_vec = '0; in_valid = 1'b0;
        test_result = '0; gold_result = '0; mask = '1;
        start4 = 1'b0; num_vec4 = '0;
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy_done_pass", {busy, done, pass}, 0);
        chk("reset_vec_count", vec_count, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Directed five-vector run, full mask
        start = 1'b1; num_vec = 16'd5;
        tick();
        start = 1'b0;
        chk("t1_busy_after_start", busy, 1);
        chk("t1_vec_count_cleared", vec_count, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; test_result = t1_test[i]; gold_result = t1_gold[i];
            tick();
            chk("t1_match_valid", match_valid, 1);
            chk("t1_match", match, t1_match[i]);
        end
        in_valid = 1'b0;
        chk("t1_err_count", err_count, 2);
        chk("t1_first_err_idx", first_err_idx, 1);
        chk("t1_first_err_test", first_err_test, 32'h1);
        chk("t1_first_err_gold", first_err_gold, 32'h0);
        chk("t1_vec_count", vec_count, 5);
        chk("t1_done_pass", {done, pass}, 2'b10);
        chk("t1_in_ready_low", in_ready, 0);
        tick();
        chk("t1_strobe_one_cycle", match_valid, 0);

        // Masking: upper-half compare, then mask=0 with a full difference
        start = 1'b1; num_vec = 16'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; mask = 32'hFFFF0000;
        test_result = 32'h1234ABCD; gold_result = 32'h1234FFFF;
        tick();
        chk("t2_mask_match", match, 1);
        mask = 32'h0; test_result = 32'hFFFFFFFF; gold_result = 32'h0;
        tick();
        in_valid = 1'b0; mask = '1;
        chk("t2_mask0_match", match, 1);
        chk("t2_err_count", err_count, 0);
        chk("t2_pass", {done, pass}, 2'b11);

        // Handshake: valid every other cycle, extras in DONE must be ignored
        start = 1'b1; num_vec = 16'd3;
        tick();
        start = 1'b0;
        strobes = 0;
        test_result = 32'h7; gold_result = 32'h7;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 5) ? (i % 2 == 0) : 1'b1;
            if (i >= 5) gold_result = 32'h8;
            tick();
            if (match_valid) strobes++;
            if (i == 3) chk("t3_ready_before_done", {in_ready, done}, 2'b10);
            if (i == 4) chk("t3_ready_drops_with_done", {in_ready, done}, 2'b01);
        end
        in_valid = 1'b0;
        chk("t3_strobes", strobes, 3);
        chk("t3_vec_count", vec_count, 3);
        chk("t3_err_count", err_count, 0);

        // num_vec = 0 finishes immediately
        start = 1'b1; num_vec = 16'd0;
        tick();
        start = 1'b0;
        chk("t4_done_pass", {done, pass, busy}, 3'b110);
        chk("t4_vec_count", vec_count, 0);

        // Narrow counters: fill to all-ones, extras in DONE, restart mid-run
        start4 = 1'b1; num_vec4 = 4'd15;
        tick();
        start4 = 1'b0;
        in_valid = 1'b1; test_result = 32'h1; gold_result = 32'h0;
        for (int i = 0; i < 20; i++) tick();
        chk("t5_err_sat", err_count4, 4'hF);
        chk("t5_vec_capped", vec_count4, 4'hF);
        chk("t5_done4", {done4, pass4}, 2'b10);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_midrun_err", err_count4, 3);
        start4 = 1'b1;
        tick();
        start4 = 1'b0; in_valid = 1'b0;
        chk("t5_restart_counts", {vec_count4, err_count4}, 8'h00);
        chk("t5_restart_busy", busy4, 1);
        chk("t5_start_vector_dropped", match_valid4, 0);

        // Asynchronous reset mid-run
        start = 1'b1; num_vec = 16'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; test_result = 32'h5; gold_result = 32'h5;
        tick();
        test_result = 32'h7; gold_result = 32'h6;
        tick();
        chk("t6_pre_reset_err", err_count, 1);
        #2;
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("t6_async_counts", {vec_count, err_count, first_err_idx}, 0);
        chk("t6_async_capture", {first_err_test, first_err_gold}, 0);
        chk("t6_async_flags", {in_ready, match, match_valid, busy, done, pass}, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t6_idle_after_reset", {busy, done}, 0);
        start = 1'b1; num_vec = 16'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; test_result = 32'h9; gold_result = 32'h9;
        tick();
        in_valid = 1'b0;
        chk("t6_final_match", {match_valid, match}, 2'b11);
        chk("t6_final_pass", {done, pass}, 2'b11);
        chk("t6_final_vec_count", vec_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
